// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register with valid/ready handshake,
// a two-entry skid store (main + skid), hazard stall and branch/exception
// flush. in_ready depends only on registered state, so no combinational path
// runs from out_ready or stall back to the upstream stage.
// Optional feature: define PIPE_STAGE_STAT_EN to enable the saturating
// stall-cycle counter on stall_cnt. Otherwise stall_cnt is tied to zero.
module pipe_stage_reg #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   main_data_reg;
    logic [CTRL_W-1:0]   main_ctrl_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [CTRL_W-1:0]   skid_ctrl_reg;

    logic                main_valid;
    logic                in_fire;
    logic                out_fire;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;

    assign main_valid = (state_reg != EMPTY);
    assign in_ready   = (state_reg != SKID);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_valid & out_ready & ~stall;

    // A held stage shows a bubble; payload stays put so only ctrl is muxed.
    assign out_valid  = main_valid & ~stall;
    assign out_data   = main_data_reg;
    assign out_ctrl   = out_valid ? main_ctrl_reg : NOP_CTRL;

    // Next-state and load-enable decode; flush overrides every handshake event.
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next = SKID;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    state_next     = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State and payload registers; reset clears everything, including payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= NOP_CTRL;
            skid_data_reg <= '0;
            skid_ctrl_reg <= NOP_CTRL;
        end else begin
            state_reg <= state_next;
            if (load_main_in) begin
                main_data_reg <= in_data;
                main_ctrl_reg <= in_ctrl;
            end else if (load_main_skid) begin
                main_data_reg <= skid_data_reg;
                main_ctrl_reg <= skid_ctrl_reg;
            end
            if (load_skid) begin
                skid_data_reg <= in_data;
                skid_ctrl_reg <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_STAT_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles where a held beat could not leave; saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= 16'h0000;
        end else if (main_valid && (stall || !out_ready) && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus randomized traffic,
// checked by a scoreboard. The reference model is a FIFO of accepted beats
// (capacity 2) that is emptied on flush or reset; a monitor compares every
// cycle's outputs against the head of that FIFO.
module tb_pipe_stage_reg;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        logic [63:0] d;
        logic [15:0] c;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt;

    // Scoreboard and model state
    beat_t q[$];
    beat_t pend;
    bit    push_pending  = 1'b0;
    bit    clear_pending = 1'b0;
    bit    rst_pending   = 1'b0;
    bit    zero_flag     = 1'b1;
    bit    checking      = 1'b0;
    int    exp_cnt       = 0;
    int    n_checks      = 0;
    int    n_fail        = 0;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; acc reports whether the model accepted the beat.
    task automatic drive_cycle(input bit v, input logic [63:0] d, input logic [15:0] c,
                               input bit st, input bit fl, input bit ordy, input bit r,
                               output bit acc);
        @(posedge clk);
        // Commit what happened at this edge into the model.
        if (clear_pending) begin
            q.delete();
            if (rst_pending) zero_flag = 1'b1;
        end else if (push_pending) begin
            q.push_back(pend);
            zero_flag = 1'b0;
        end
        clear_pending = 1'b0;
        push_pending  = 1'b0;
        rst_pending   = 1'b0;
        #1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        #2;
        if (checking) check("in_ready", in_ready, (q.size() != 2));
        acc = v && (q.size() != 2);
        if (acc && !fl && !r) begin
            pend.d       = d;
            pend.c       = c;
            push_pending = 1'b1;
        end
        clear_pending = fl || r;
        rst_pending   = r;
    endtask

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, ordy, 1'b0, a);
    endtask

    // Monitor: compares outputs to the model once per cycle, away from the edge.
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (checking) begin
                ev = (q.size() > 0) && !stall;
                check("out_valid", out_valid, ev);
                check("out_ctrl", out_ctrl, ev ? q[0].c : NOP);
                if (ev) check("out_data", out_data, q[0].d);
                else if (zero_flag) check("out_data_reset", out_data, 64'h0);
                check("stall_cnt", stall_cnt, exp_cnt[15:0]);
`ifdef PIPE_STAGE_STAT_EN
                if ((q.size() > 0) && (stall || !out_ready) && exp_cnt < 65535) exp_cnt++;
`endif
                if (ev && out_ready) void'(q.pop_front());
                if (rst) exp_cnt = 0;
            end
        end
    end

    initial begin
        bit a;
        bit v, st, fl, ordy, r;
        logic [63:0] d;
        logic [15:0] c;
        int hold_n;

        // Initial reset
        drive_cycle(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        drive_cycle(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        checking = 1'b1;
        idle(2, 1'b1);

        // Streaming: 4 beats back to back
        for (int i = 1; i <= 4; i++)
            drive_cycle(1'b1, 64'(i), 16'h0010 + 16'(i), 1'b0, 1'b0, 1'b1, 1'b0, a);
        idle(2, 1'b1);

        // Backpressure: A, B fill the store, C waits until accepted
        drive_cycle(1'b1, 64'hA, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'hB, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'hC, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'hC, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, a);
        a = 1'b0;
        for (int i = 0; i < 6 && !a; i++)
            drive_cycle(1'b1, 64'hC, 16'h000C, 1'b0, 1'b0, 1'b1, 1'b0, a);
        check("beat_C_accepted", a, 1'b1);
        idle(3, 1'b1);

        // Stall: 0x5/0x00FF held for 3 cycles then presented once
        drive_cycle(1'b1, 64'h5, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        idle(3, 1'b1);

        // Flush in SKID with an incoming beat
        drive_cycle(1'b1, 64'h11, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'h22, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'h33, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0, a);
        idle(4, 1'b1);

        // Reset in SKID
        drive_cycle(1'b1, 64'h44, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'h55, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 64'h66, 16'h0066, 1'b1, 1'b1, 1'b0, 1'b1, a);
        idle(4, 1'b1);

        // Statistic: a beat held against backpressure for a long time
`ifdef PIPE_STAGE_STAT_EN
        hold_n = 70000;
`else
        hold_n = 200;
`endif
        drive_cycle(1'b1, 64'h77, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, a);
        idle(hold_n, 1'b0);
        @(negedge clk);
        #1;
`ifdef PIPE_STAGE_STAT_EN
        check("stall_cnt_saturated", stall_cnt, 16'hFFFF);
`else
        check("stall_cnt_disabled", stall_cnt, 16'h0000);
`endif
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            d    = {$urandom, $urandom};
            c    = 16'($urandom);
            st   = ($urandom_range(0, 99) < 15);
            fl   = ($urandom_range(0, 99) < 3);
            ordy = ($urandom_range(0, 9) < 7);
            r    = ($urandom_range(0, 99) == 0);
            drive_cycle(v, d, c, st, fl, ordy, r, a);
        end

        // Drain and confirm nothing is left in flight
        idle(6, 1'b1);
        @(negedge clk);
        #1;
        check("drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the datapath payload (PC, instruction, operands, addresses).
REQ-002 SHALL have parameter CTRL_W, default 16, width of the EX/MEM/WB control payload.
REQ-003 SHALL have parameter NOP_CTRL, default 0 (CTRL_W bits), the control value presented for a bubble.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  the upstream stage presents a beat.
REQ-007 SHALL have port in_ready  output  1  the stage accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream control.
REQ-010 SHALL have port stall  input  1  hazard-unit hold request.
REQ-011 SHALL have port flush  input  1  branch/exception squash.
REQ-012 SHALL have port out_valid  output  1  the stage presents a beat downstream.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_data  output  DATA_W  registered payload.
REQ-015 SHALL have port out_ctrl  output  CTRL_W  registered control, or NOP_CTRL when bubbling.
REQ-016 SHALL have port stall_cnt  output  16  stall-cycle statistic (see Configuration).

Function
REQ-017 SHALL hold a two-entry store: main (drives outputs) and skid, with states EMPTY, FULL (main only) and SKID (both).
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = main_valid & out_ready & ~stall.
REQ-019 SHALL drive in_ready = (state != SKID) from registers only; no combinational path from out_ready or stall.
REQ-020 SHALL transition EMPTY->FULL on in_fire, loading main with the input beat.
REQ-021 SHALL, in FULL, on in_fire & out_fire, reload main and stay FULL; on in_fire only, load skid and go to SKID; on out_fire only, go to EMPTY.
REQ-022 SHALL, in SKID, on out_fire, move skid into main and go to FULL; otherwise hold.
REQ-023 SHALL drive out_valid = main_valid & ~stall, and out_ctrl = NOP_CTRL whenever out_valid is 0.
REQ-024 SHALL keep out_data at its last value while out_valid is 0.
REQ-025 SHALL, on flush, go to EMPTY next cycle regardless of state and discard any same-cycle in_fire; flush SHALL take precedence over stall and all handshake events.
REQ-026 SHALL give a latency of 1 cycle from in_fire in EMPTY to out_valid.
REQ-027 SHALL sustain 1 beat/cycle when out_ready=1 and stall=0, and preserve beat order under any backpressure.

Reset
REQ-028 SHALL, while rst=1, force state EMPTY, out_valid=0, out_data=0, out_ctrl=NOP_CTRL, in_ready=1 on the following cycle, and stall_cnt=0.
REQ-029 SHALL, if rst asserts mid-transfer, drop all stored beats; rst SHALL take precedence over flush.

Configuration
REQ-030 SHALL, when macro PIPE_STAGE_STAT_EN is defined, increment stall_cnt each cycle with main_valid & (stall | ~out_ready), saturating at 16'hFFFF, cleared only by rst.
REQ-031 SHALL, when PIPE_STAGE_STAT_EN is undefined, drive stall_cnt constant 16'h0000 and implement no counter logic.

Verification
REQ-032 SHALL cover streaming: 4 beats, data 0x1..0x4, out_ready=1 -> out_data 0x1..0x4 on consecutive cycles starting 1 cycle after first in_fire.
REQ-033 SHALL cover backpressure: beats 0xA, 0xB, 0xC with out_ready=0 -> in_ready=0 after 0xB accepted, 0xC held upstream; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-034 SHALL cover stall: main holds 0x5 with ctrl 0x00FF, stall=1 for 3 cycles -> out_valid=0, out_ctrl=NOP_CTRL; on release, 0x5/0x00FF presented once.
REQ-035 SHALL cover flush: in SKID with in_valid=1 and flush=1 -> next cycle EMPTY, out_valid=0, in_ready=1, no stored or incoming beat ever emerges.
REQ-036 SHALL cover reset mid-operation: rst=1 in SKID -> next cycle out_data=0, out_ctrl=NOP_CTRL, out_valid=0, stall_cnt=0.
REQ-037 SHALL cover statistic with PIPE_STAGE_STAT_EN: 70000 held cycles -> stall_cnt=16'hFFFF; without the macro -> stall_cnt=0.
